// File: rtl/key_debounce.sv
// Four-channel push-button conditioner: 2-flop synchroniser plus an independent
// stable-time debounce FSM per key, with registered active-low level and press/release strobes.
module key_debounce #(
    parameter int unsigned KEY_W   = 4,
    parameter int unsigned CNT_MAX = 1_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_out,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release
);

    localparam int unsigned CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    logic [KEY_W-1:0] s1;
    logic [KEY_W-1:0] s2;

    // Synchroniser idles at 1 so reset never looks like a press.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= key_in;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < KEY_W; i++) begin : g_chan
        logic [1:0]       state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             out_q;
        logic             press_q;
        logic             rel_q;

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                state_q <= ST_RELEASED;
                cnt_q   <= '0;
                out_q   <= 1'b1;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                case (state_q)
                    ST_RELEASED: begin
                        if (!s2[i]) begin
                            state_q <= ST_PRESS_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (s2[i]) begin
                            state_q <= ST_RELEASED;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= ST_PRESSED;
                            cnt_q   <= '0;
                            out_q   <= 1'b0;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_PRESSED: begin
                        if (s2[i]) begin
                            state_q <= ST_RELEASE_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (!s2[i]) begin
                            state_q <= ST_PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= ST_RELEASED;
                            cnt_q   <= '0;
                            out_q   <= 1'b1;
                            rel_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_RELEASED;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign key_out[i]     = out_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with CNT_MAX = 16: directed scenarios with fixed-edge expectations
// plus randomized bouncing checked against a run-length model of the debounce rule.
module tb_key_debounce;

    localparam int KEY_W   = 4;
    localparam int CNT_MAX = 16;
    localparam int LAT     = CNT_MAX + 2;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic [KEY_W-1:0] key_in  = 4'hF;
    logic [KEY_W-1:0] key_out;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;

    int errors = 0;
    int checks = 0;

    key_debounce #(
        .KEY_W  (KEY_W),
        .CNT_MAX(CNT_MAX)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .key_out    (key_out),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 sys_clk = ~sys_clk;

    // Model: raw samples delayed two edges; a key flips once the delayed sample has
    // disagreed with the current level for CNT_MAX+1 consecutive edges.
    logic [KEY_W-1:0] m_d1, m_d2, m_out, m_press, m_rel;
    int               m_run[KEY_W];

    task automatic model_reset();
        m_d1    = '1;
        m_d2    = '1;
        m_out   = '1;
        m_press = '0;
        m_rel   = '0;
        for (int i = 0; i < KEY_W; i++) m_run[i] = 0;
    endtask

    task automatic tick();
        logic [KEY_W-1:0] seen;
        @(posedge sys_clk);
        if (sys_rst) begin
            model_reset();
        end else begin
            seen    = m_d2;
            m_d2    = m_d1;
            m_d1    = key_in;
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < KEY_W; i++) begin
                if (seen[i] != m_out[i]) begin
                    m_run[i]++;
                    if (m_run[i] == CNT_MAX + 1) begin
                        m_out[i] = seen[i];
                        if (seen[i]) m_rel[i] = 1'b1;
                        else m_press[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic set_keys(input logic [KEY_W-1:0] v);
        @(negedge sys_clk);
        key_in = v;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        key_in  = 4'hF;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if ({key_out, key_press, key_release} !== {4'hF, 8'h00}) begin
                errors++;
                $display("FAIL reset_hold: out=%b press=%b rel=%b, want 1111/0000/0000",
                         key_out, key_press, key_release);
            end
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int j = 0; j < 100; j++) begin
            tick();
            checks++;
            if ({key_out, key_press, key_release} !== {4'hF, 8'h00}) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: out=%b press=%b rel=%b, want 1111/0000/0000",
                         j, key_out, key_press, key_release);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [KEY_W-1:0] eo, ep;
        set_keys(4'b1110);
        for (int j = 0; j <= LAT; j++) begin
            tick();
            eo = (j == LAT) ? 4'b1110 : 4'b1111;
            ep = (j == LAT) ? 4'b0001 : 4'b0000;
            checks++;
            if ({key_out, key_press, key_release} !== {eo, ep, 4'h0}) begin
                errors++;
                $display("FAIL clean_press edge+%0d: out=%b press=%b rel=%b, want %b/%b/0000",
                         j, key_out, key_press, key_release, eo, ep);
            end
        end
        tick();
        checks++;
        if ({key_out, key_press, key_release} !== {4'b1110, 8'h00}) begin
            errors++;
            $display("FAIL clean_press_after: out=%b press=%b rel=%b, want 1110/0000/0000",
                     key_out, key_press, key_release);
        end
    endtask

    task automatic test_release();
        logic [KEY_W-1:0] eo, er;
        set_keys(4'b1111);
        for (int j = 0; j < 8; j++) tick();
        set_keys(4'b1110);  // glitch back low restarts the release count
        for (int j = 0; j < 5; j++) tick();
        checks++;
        if ({key_out, key_press, key_release} !== {4'b1110, 8'h00}) begin
            errors++;
            $display("FAIL release_glitch: out=%b press=%b rel=%b, want 1110/0000/0000",
                     key_out, key_press, key_release);
        end
        set_keys(4'b1111);
        for (int j = 0; j <= LAT; j++) begin
            tick();
            eo = (j == LAT) ? 4'b1111 : 4'b1110;
            er = (j == LAT) ? 4'b0001 : 4'b0000;
            checks++;
            if ({key_out, key_press, key_release} !== {eo, 4'h0, er}) begin
                errors++;
                $display("FAIL release edge+%0d: out=%b press=%b rel=%b, want %b/0000/%b",
                         j, key_out, key_press, key_release, eo, er);
            end
        end
        tick();
        checks++;
        if (key_release !== 4'h0) begin
            errors++;
            $display("FAIL release_one_cycle: rel=%b, want 0000", key_release);
        end
    endtask

    task automatic test_bounce();
        logic [KEY_W-1:0] pat[4] = '{4'b1101, 4'b1111, 4'b1101, 4'b1111};
        int               len[4] = '{10, 3, 12, 4};
        logic [KEY_W-1:0] eo, ep;
        for (int s = 0; s < 4; s++) begin
            set_keys(pat[s]);
            for (int j = 0; j < len[s]; j++) begin
                tick();
                checks++;
                if ({key_out, key_press, key_release} !== {4'hF, 8'h00}) begin
                    errors++;
                    $display("FAIL bounce seg%0d cyc%0d: out=%b press=%b rel=%b, want 1111/0/0",
                             s, j, key_out, key_press, key_release);
                end
            end
        end
        set_keys(4'b1101);
        for (int j = 0; j <= LAT; j++) begin
            tick();
            eo = (j == LAT) ? 4'b1101 : 4'b1111;
            ep = (j == LAT) ? 4'b0010 : 4'b0000;
            checks++;
            if ({key_out, key_press, key_release} !== {eo, ep, 4'h0}) begin
                errors++;
                $display("FAIL bounce_hold edge+%0d: out=%b press=%b rel=%b, want %b/%b/0000",
                         j, key_out, key_press, key_release, eo, ep);
            end
        end
        set_keys(4'b1111);
        for (int j = 0; j < LAT + 2; j++) tick();
        checks++;
        if ({key_out, key_release} !== {4'hF, 4'h0}) begin
            errors++;
            $display("FAIL bounce_release: out=%b rel=%b, want 1111/0000", key_out, key_release);
        end
    endtask

    task automatic test_simultaneous();
        logic [KEY_W-1:0] eo, ep;
        set_keys(4'b0000);
        for (int j = 0; j <= LAT; j++) begin
            tick();
            eo = (j == LAT) ? 4'b0000 : 4'b1111;
            ep = (j == LAT) ? 4'b1111 : 4'b0000;
            checks++;
            if ({key_out, key_press, key_release} !== {eo, ep, 4'h0}) begin
                errors++;
                $display("FAIL simultaneous edge+%0d: out=%b press=%b rel=%b, want %b/%b/0000",
                         j, key_out, key_press, key_release, eo, ep);
            end
        end
        set_keys(4'b1111);
        for (int j = 0; j <= LAT; j++) begin
            tick();
            checks++;
            if ({key_out, key_press, key_release} !== {m_out, m_press, m_rel}) begin
                errors++;
                $display("FAIL simul_release edge+%0d: out=%b press=%b rel=%b, model %b/%b/%b",
                         j, key_out, key_press, key_release, m_out, m_press, m_rel);
            end
        end
        checks++;
        if (key_release !== 4'b1111) begin
            errors++;
            $display("FAIL simul_release_strobe: rel=%b, want 1111", key_release);
        end
    endtask

    task automatic test_reset_mid_press();
        logic [KEY_W-1:0] eo, ep;
        set_keys(4'b1011);
        for (int j = 0; j <= LAT; j++) tick();
        checks++;
        if (key_out !== 4'b1011) begin
            errors++;
            $display("FAIL rst_mid_setup: out=%b, want 1011", key_out);
        end
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({key_out, key_press, key_release} !== {4'hF, 8'h00}) begin
            errors++;
            $display("FAIL rst_mid_async: out=%b press=%b rel=%b, want 1111/0000/0000",
                     key_out, key_press, key_release);
        end
        tick();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int j = 0; j <= LAT; j++) begin
            tick();
            eo = (j == LAT) ? 4'b1011 : 4'b1111;
            ep = (j == LAT) ? 4'b0100 : 4'b0000;
            checks++;
            if ({key_out, key_press, key_release} !== {eo, ep, 4'h0}) begin
                errors++;
                $display("FAIL rst_mid_repress edge+%0d: out=%b press=%b rel=%b, want %b/%b/0000",
                         j, key_out, key_press, key_release, eo, ep);
            end
        end
        set_keys(4'b1111);
        for (int j = 0; j < LAT + 2; j++) tick();
    endtask

    task automatic test_random();
        logic [KEY_W-1:0] prev_p, prev_r, lvl;
        int               seg, mode;
        prev_p = '0;
        prev_r = '0;
        lvl    = 4'hF;
        for (int s = 0; s < 120; s++) begin
            seg  = $urandom_range(40, 1);
            mode = $urandom_range(2, 0);
            if (mode != 0) lvl = KEY_W'($urandom);
            for (int j = 0; j < seg; j++) begin
                @(negedge sys_clk);
                key_in = (mode == 0) ? KEY_W'($urandom) : lvl;
                tick();
                checks++;
                if ({key_out, key_press, key_release} !== {m_out, m_press, m_rel}) begin
                    errors++;
                    $display("FAIL random s%0d: out=%b press=%b rel=%b, model %b/%b/%b",
                             s, key_out, key_press, key_release, m_out, m_press, m_rel);
                end
                checks++;
                if (((key_press & key_release) | (key_press & prev_p) |
                     (key_release & prev_r)) !== 4'h0) begin
                    errors++;
                    $display("FAIL strobe_rules s%0d: press=%b rel=%b prev %b/%b, want no overlap",
                             s, key_press, key_release, prev_p, prev_r);
                end
                prev_p = key_press;
                prev_r = key_release;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_reset_mid_press();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
